// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, issues back-pressured imem fetches, applies branch redirects
// and discards stale responses, feeding an in-order {pc, word} buffer toward decode.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic        misalign_err
);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} state_t;

    state_t          state, state_next;
    logic [31:0]     fetch_pc, req_pc, target;
    logic            outstanding, err;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     fifo_pc   [BUF_DEPTH];
    logic [31:0]     fifo_data [BUF_DEPTH];
    logic            grant, rv, redirect, bad_target, push, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == PW'(BUF_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign target     = br_pc + br_offset;
    assign bad_target = target[1:0] != 2'b00;
    assign redirect   = br_valid && state != HALT;
    assign grant      = imem_req && imem_gnt;
    // a response only counts when a granted request is actually in flight
    assign rv         = imem_rvalid && outstanding;
    assign push       = state == WAIT && rv && !redirect;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        state_next = REQ;
            REQ:         state_next = grant ? WAIT : REQ;
            WAIT, DRAIN: state_next = rv ? REQ : state;
            default:     state_next = HALT;
        endcase
        if (redirect)
            state_next = bad_target ? HALT : (grant || (outstanding && !rv)) ? DRAIN : REQ;
    end

    always_comb begin
        imem_req     = state == REQ && (int'(count) + int'(outstanding) < BUF_DEPTH);
        imem_addr    = fetch_pc;
        inst_valid   = count != '0;
        inst_pc      = fifo_pc[rd_ptr];
        inst_data    = fifo_data[rd_ptr];
        misalign_err = err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            err         <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (redirect && !bad_target)
                fetch_pc <= target;
            outstanding <= grant || (outstanding && !imem_rvalid);
            if (redirect && bad_target)
                err <= 1'b1;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= req_pc;
                    fifo_data[wr_ptr] <= imem_rdata;
                    wr_ptr            <= bump(wr_ptr);
                end
                if (pop)
                    rd_ptr <= bump(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of fetch sequencing, backpressure, redirects and error halt
// against a one-cycle-latency memory responder with optional response hold-off.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_offset = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready = 1'b0;
    logic        misalign_err;

    int          total = 0;
    int          bad = 0;
    logic        hold = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_pc(br_pc), .br_offset(br_offset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: log grants/consumption, then drive the memory response one cycle later
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = imem_req && imem_gnt;
        a = imem_addr;
        if (imem_rvalid) pend = 1'b0;
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        if (g) gq.push_back(a);
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        if (g) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        imem_rvalid = pend && !hold;
        imem_rdata  = imem_rvalid ? word(pend_addr) : 32'h0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic redirect(input logic [31:0] pc, input logic [31:0] off);
        br_valid  = 1'b1;
        br_pc     = pc;
        br_offset = off;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hold  = 1'b0;
        ticks(2);
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        inst_ready  = 1'b1;
        gq.delete();
        got_pc.delete();
        got_data.delete();
    endtask

    initial begin
        ticks(2);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_data", inst_data, 32'h0);
        check("rst_err", 32'(misalign_err), 0);

        // sequential fetch
        do_reset();
        check("seq_req_c0", 32'(imem_req), 0);
        tick();
        check("seq_req_c1", 32'(imem_req), 1);
        ticks(9);
        check("seq_g0", gq[0], 32'h0);
        check("seq_g1", gq[1], 32'h4);
        check("seq_g2", gq[2], 32'h8);
        check("seq_g3", gq[3], 32'hC);
        check("seq_pc0", got_pc[0], 32'h0);
        check("seq_pc1", got_pc[1], 32'h4);
        check("seq_pc2", got_pc[2], 32'h8);
        check("seq_pc3", got_pc[3], 32'hC);
        check("seq_d0", got_data[0], 32'hC0DE_0000);
        check("seq_d3", got_data[3], 32'hC0DE_000C);

        // backpressure
        do_reset();
        inst_ready = 1'b0;
        ticks(8);
        check("bp_grants", 32'(gq.size()), 2);
        check("bp_req", 32'(imem_req), 0);
        check("bp_valid", 32'(inst_valid), 1);
        check("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        check("bp_resume_req", 32'(imem_req), 1);
        check("bp_resume_addr", imem_addr, 32'h8);

        // redirect while waiting for the response
        do_reset();
        hold = 1'b1;
        ticks(2);
        redirect(32'h10, 32'h10);
        check("wait_valid", 32'(inst_valid), 0);
        check("wait_req", 32'(imem_req), 0);
        hold = 1'b0;
        ticks(6);
        check("wait_g1", gq[1], 32'h20);
        check("wait_pc", got_pc[0], 32'h20);
        check("wait_data", got_data[0], 32'hC0DE_0020);
        check("wait_cnt", 32'(got_pc.size()), 1);

        // redirect in the same cycle as rvalid
        do_reset();
        ticks(2);
        redirect(32'h40, 32'h8);
        check("rv_valid", 32'(inst_valid), 0);
        check("rv_req", 32'(imem_req), 1);
        check("rv_addr", imem_addr, 32'h48);
        ticks(3);
        check("rv_pc", got_pc[0], 32'h48);
        check("rv_cnt", 32'(got_pc.size()), 1);

        // redirect in the same cycle as grant
        do_reset();
        tick();
        redirect(32'h100, 32'h20);
        check("gnt_req_drain", 32'(imem_req), 0);
        check("gnt_valid", 32'(inst_valid), 0);
        tick();
        check("gnt_req", 32'(imem_req), 1);
        check("gnt_addr", imem_addr, 32'h120);
        ticks(3);
        check("gnt_pc", got_pc[0], 32'h120);
        check("gnt_cnt", 32'(got_pc.size()), 1);

        // negative offset wrapping below zero, ungranted request withdrawn
        do_reset();
        imem_gnt = 1'b0;
        tick();
        redirect(32'h4, 32'hFFFF_FFF8);
        check("wrap_req", 32'(imem_req), 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        ticks(2);
        check("wrap_g0", gq[0], 32'hFFFF_FFFC);
        check("wrap_next", imem_addr, 32'h0);
        check("wrap_pc", inst_pc, 32'hFFFF_FFFC);

        // misaligned target halts until reset
        do_reset();
        ticks(2);
        redirect(32'h8, 32'h2);
        check("mis_err", 32'(misalign_err), 1);
        check("mis_req", 32'(imem_req), 0);
        check("mis_valid", 32'(inst_valid), 0);
        ticks(3);
        check("mis_err_hold", 32'(misalign_err), 1);
        check("mis_req_hold", 32'(imem_req), 0);
        reset = 1'b0;
        tick();
        check("mis_rst_err", 32'(misalign_err), 0);
        check("mis_rst_addr", imem_addr, 32'h0);
        check("mis_rst_pc", inst_pc, 32'h0);
        reset = 1'b1;
        tick();
        check("mis_restart_req", 32'(imem_req), 1);
        check("mis_restart_addr", imem_addr, 32'h0);

        // response to a pre-reset request arrives after reset and must be ignored
        do_reset();
        hold = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        hold  = 1'b0;
        tick();
        tick();
        check("late_rv_valid", 32'(inst_valid), 0);
        tick();
        check("late_valid", 32'(inst_valid), 1);
        check("late_pc", inst_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory request port. It issues sequential fetches (PC+4), applies taken-branch redirects (branch PC + signed offset), and discards in-flight responses made stale by a redirect. Fetched words go into a small in-order buffer toward decode, with a valid/ready handshake. It sits between the branch-resolution logic and decode, replacing free-running PC update with a controlled, back-pressured sequence.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- BUF_DEPTH, 2, instruction buffer entries (≥1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- br_valid  in  1  taken-branch redirect, single-cycle pulse
- br_pc  in  32  PC of the resolved branch
- br_offset  in  32  signed byte offset; target = br_pc + br_offset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req=1 and not granted
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in order, ≥1 cycle after grant)
- imem_rdata  in  32  instruction word
- inst_valid  out  1  buffer head valid
- inst_pc  out  32  PC of head instruction
- inst_data  out  32  head instruction word
- inst_ready  in  1  decode accepts head
- misalign_err  out  1  sticky: redirect target not word aligned

## Operation
- Registers: fetch_pc, state, outstanding (0/1), FIFO of {pc, word}, count, err.
- States: IDLE, REQ, WAIT, DRAIN, HALT. Reset value IDLE.
- IDLE → REQ unconditionally.
- REQ: imem_req = (count + outstanding < BUF_DEPTH); imem_addr = fetch_pc. On imem_req && imem_gnt: fetch_pc += 4 (mod 2^32), outstanding=1, → WAIT.
- WAIT: on imem_rvalid push {pc of request, imem_rdata}, outstanding=0, → REQ.
- DRAIN: outstanding response is stale; on imem_rvalid drop it, outstanding=0, → REQ.
- Redirect (br_valid=1, priority over all normal transitions except reset):
  - target[1:0] != 0 → err=1, FIFO flushed, → HALT (if outstanding, the response is dropped silently in HALT).
  - else fetch_pc = target; FIFO flushed (count=0).
  - From REQ without grant same cycle → REQ (new address next cycle; the ungranted request is withdrawn — the sole exception to the address-stable rule).
  - From REQ with grant same cycle, or from WAIT without rvalid → DRAIN.
  - From WAIT with rvalid same cycle → response dropped, → REQ.
  - From DRAIN → DRAIN; from IDLE → REQ.
- HALT: imem_req=0, inst_valid=0; exits only by reset.
- FIFO: inst_valid = (count != 0); pop on inst_valid && inst_ready. Push and pop in the same cycle are both performed. Overflow cannot occur because of credit rule count + outstanding ≤ BUF_DEPTH.
- Target arithmetic is 32-bit two's complement, wraps modulo 2^32.

## Timing
- Reset values (cycle after edge with reset=0): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_pc=0, inst_data=0, misalign_err=0, state IDLE, count=0, outstanding=0.
- First imem_req rises 1 cycle after the first cycle with reset=1.
- Grant→rvalid=1 cycle: rvalid at cycle N gives inst_valid at N+1. Steady state with 1-cycle memory is one fetch every 2 cycles.
- br_valid at cycle N: inst_valid=0 at N+1. In REQ without grant, imem_addr=target at N+1.
- Reset mid-operation overrides everything: FIFO cleared, outstanding cleared, and any later rvalid ignored until the next grant.
- misalign_err rises the cycle after the offending br_valid and stays high until reset.

## Test plan
- Sequential fetch: release reset, always grant, rvalid 1 cycle after grant, inst_ready=1 → imem_addr 0x0, 0x4, 0x8…; inst_pc/inst_data match, in order.
- Backpressure: inst_ready=0, BUF_DEPTH=2 → exactly 2 grants, then imem_req=0. Raising inst_ready resumes fetch at 0x8.
- Redirect during WAIT: br_pc=0x10, br_offset=0x10 before rvalid → stale word never appears, FIFO flushed, next imem_addr=0x20, next inst_pc=0x20.
- Redirect same cycle as rvalid, and same cycle as grant → no stale instruction delivered, next fetch address equals target.
- Negative wrap: br_pc=0x4, br_offset=0xFFFF_FFF8 → imem_addr=0xFFFF_FFFC; next sequential fetch 0x0.
- Misaligned target: br_pc=0x8, br_offset=0x2 → misalign_err=1, imem_req=0, inst_valid=0 held. Reset pulse → all outputs return to reset values and fetch restarts at RESET_PC.
